// File: rtl/muldiv_exec_unit.sv
// Iterative RV32M multiply/divide execute unit with valid/ready handshakes.
// Optional early-out for trivial operands: define MULDIV_EARLY_OUT_EN.
module muldiv_exec_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic            func7_0,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [2:0]            r_func3;
    logic [XLEN-1:0]       r_mcand;
    logic [2*XLEN-1:0]     r_acc;
    logic [XLEN-1:0]       r_rem;
    logic                  r_neg;
    logic                  r_div0;
    logic [CNT_W-1:0]      r_cnt;
    logic [XLEN-1:0]       r_result;

    logic                  w_unused_ctrl;
    logic                  w_accept;
    logic                  w_finish;
    logic                  w_a_signed;
    logic                  w_b_signed;
    logic                  w_sa;
    logic                  w_sb;
    logic [XLEN-1:0]       w_mag_a;
    logic [XLEN-1:0]       w_mag_b;
    logic                  w_neg;
    logic                  w_early;
    logic [XLEN-1:0]       w_early_val;
    logic [XLEN-1:0]       w_addend;
    logic [XLEN:0]         w_sum;
    logic [2*XLEN-1:0]     w_acc_mul;
    logic [XLEN:0]         w_shift;
    logic [XLEN:0]         w_trial;
    logic                  w_ge;
    logic [XLEN-1:0]       w_rem_next;
    logic [2*XLEN-1:0]     w_prod;
    logic [XLEN-1:0]       w_final;

    // alu_ctrl[3] carries no information for the M-extension ops.
    assign w_unused_ctrl = alu_ctrl[3];

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign result    = r_result;

    assign w_accept = in_valid & func7_0 & (r_state == StIdle) & ~flush;
    assign w_finish = (r_state == StBusy) && (r_cnt == CNT_W'(XLEN));

    // Operand signedness: MUL, MULH, DIV, REM are signed x signed; MULHSU signed x unsigned.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (alu_ctrl[2:0])
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            3'b010:  w_a_signed = 1'b1;
            default: ;
        endcase
    end

    assign w_sa    = w_a_signed & op_a[XLEN-1];
    assign w_sb    = w_b_signed & op_b[XLEN-1];
    assign w_mag_a = w_sa ? -op_a : op_a;
    assign w_mag_b = w_sb ? -op_b : op_b;
    // Remainder takes the dividend sign; product and quotient take the XOR.
    assign w_neg   = (alu_ctrl[2] && alu_ctrl[1]) ? w_sa : (w_sa ^ w_sb);

`ifdef MULDIV_EARLY_OUT_EN
    always_comb begin
        w_early     = 1'b0;
        w_early_val = '0;
        if (alu_ctrl[2]) begin
            if (op_b == '0) begin
                w_early     = 1'b1;
                w_early_val = alu_ctrl[1] ? op_a : '1;
            end else if (!alu_ctrl[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1)) begin
                w_early     = 1'b1;
                w_early_val = alu_ctrl[1] ? '0 : op_a;
            end
        end else if ((op_a == '0) || (op_b == '0)) begin
            w_early = 1'b1;
        end
    end
`else
    assign w_early     = 1'b0;
    assign w_early_val = '0;
`endif

    // Shift-add multiply: r_acc = {partial high, remaining multiplier bits}.
    assign w_addend  = r_acc[0] ? r_mcand : '0;
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
    assign w_acc_mul = {w_sum, r_acc[XLEN-1:1]};

    // Restoring divide: r_acc[XLEN-1:0] shifts dividend out and quotient in.
    assign w_shift    = {r_rem, r_acc[XLEN-1]};
    assign w_trial    = w_shift - {1'b0, r_mcand};
    assign w_ge       = ~w_trial[XLEN];
    assign w_rem_next = w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];

    assign w_prod = r_neg ? -r_acc : r_acc;

    always_comb begin
        w_final = '0;
        if (r_func3[2]) begin
            if (r_func3[1]) begin
                w_final = r_neg ? -r_rem : r_rem;
            end else if (r_div0) begin
                w_final = '1;
            end else begin
                w_final = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
            end
        end else if (r_func3[1:0] == 2'b00) begin
            w_final = w_prod[XLEN-1:0];
        end else begin
            w_final = w_prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = w_early ? StDone : StBusy;
                end
            end
            StBusy: begin
                if (flush) begin
                    w_state_next = StIdle;
                end else if (w_finish) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (flush || out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_func3  <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_neg    <= 1'b0;
            r_div0   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_func3 <= alu_ctrl[2:0];
            r_mcand <= alu_ctrl[2] ? w_mag_b : w_mag_a;
            r_acc   <= {{XLEN{1'b0}}, (alu_ctrl[2] ? w_mag_a : w_mag_b)};
            r_rem   <= '0;
            r_neg   <= w_neg;
            r_div0  <= (op_b == '0);
            r_cnt   <= '0;
            if (w_early) begin
                r_result <= w_early_val;
            end
        end else if ((r_state == StBusy) && !flush) begin
            if (w_finish) begin
                r_result <= w_final;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (r_func3[2]) begin
                    r_rem            <= w_rem_next;
                    r_acc[XLEN-1:0]  <= {r_acc[XLEN-2:0], w_ge};
                end else begin
                    r_acc <= w_acc_mul;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_exec_unit.sv
// Directed bench for muldiv_exec_unit: op results, latency, backpressure, flush, reset.
// Honours MULDIV_EARLY_OUT_EN for the expected wait on trivial operands.
module tb_muldiv_exec_unit;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic        func7_0;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int n_cmp;
    int n_fail;

    // Edges counted after the accept edge until out_valid is seen.
    localparam int NormWait = 33;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int FastWait = 0;
`else
    localparam int FastWait = 33;
`endif

    muldiv_exec_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .func7_0   (func7_0),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required $finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_wait);
        int edges;
        alu_ctrl = {1'b0, f3};
        op_a     = a;
        op_b     = b;
        func7_0  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        func7_0  = 1'b0;
        check({tag, "_busy_in_ready"}, {31'b0, in_ready}, 32'd0);
        edges = 0;
        while (!out_valid && edges < 100) begin
            tick();
            edges++;
        end
        check({tag, "_wait"}, edges, exp_wait);
        check({tag, "_result"}, result, exp);
        tick();
        check({tag, "_idle_after"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        n_cmp     = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        alu_ctrl  = '0;
        func7_0   = 1'b0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        reset_n = 1'b1;
        tick();

        run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, NormWait);
        run_op("mulhu_m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NormWait);
        run_op("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, NormWait);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, NormWait);
        run_op("div_m20_6", 3'b100, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, NormWait);
        run_op("rem_m20_6", 3'b110, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, NormWait);
        run_op("divu_20_6", 3'b101, 32'd20, 32'd6, 32'd3, NormWait);
        run_op("remu_20_6", 3'b111, 32'd20, 32'd6, 32'd2, NormWait);
        run_op("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, FastWait);
        run_op("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, FastWait);
        run_op("div_neg_by0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, FastWait);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FastWait);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, FastWait);
        run_op("mul_zero", 3'b000, 32'd0, 32'h1234_5678, 32'd0, FastWait);

        // func7_0 low: request ignored.
        alu_ctrl = 4'b0000;
        op_a     = 32'd3;
        op_b     = 32'd3;
        func7_0  = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("f7_zero_ignored", {31'b0, in_ready}, 32'd1);

        // flush in IDLE blocks the accept on that edge.
        func7_0  = 1'b1;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        func7_0  = 1'b0;
        flush    = 1'b0;
        check("idle_flush_blocks", {31'b0, in_ready}, 32'd1);

        // Backpressure: DIVU 100/7 = 14 held while out_ready is low.
        out_ready = 1'b0;
        alu_ctrl  = 4'b0101;
        op_a      = 32'd100;
        op_b      = 32'd7;
        func7_0   = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        func7_0  = 1'b0;
        seen = 0;
        while (!out_valid && seen < 100) begin
            tick();
            seen++;
        end
        check("hold_wait", seen, NormWait);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_result", result, 32'd14);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        check("release_valid", {31'b0, out_valid}, 32'd0);

        // Flush mid-operation: no result, previous result kept.
        alu_ctrl = 4'b0000;
        op_a     = 32'd9;
        op_b     = 32'd9;
        func7_0  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        func7_0  = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_result_kept", result, 32'd14);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        check("flush_no_result", seen, 0);

        // Asynchronous reset mid-operation.
        alu_ctrl = 4'b0000;
        op_a     = 32'd11;
        op_b     = 32'd13;
        func7_0  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        func7_0  = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        check("arst_no_result", seen, 0);

        run_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, NormWait);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
